da_lut_builder: RTL and testbench
=================================

DA_LUT_BUILDER -- requirements
Module: da_lut_builder

Interface
REQ-001 SHALL have parameter OPSIZE, default 12, coefficient and LUT word width in bits (signed two's complement).
REQ-002 SHALL have parameter ORDER, default 6, number of filter taps.
REQ-003 SHALL have parameter PARTITION, default 2, number of LUT partitions; ORDER divisible by PARTITION; K = ORDER/PARTITION, CELLS = 2^K.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  request a new table build; sampled only in IDLE.
REQ-007 SHALL have port coef_valid  input  1  coefficient word present.
REQ-008 SHALL have port coef_data  input  OPSIZE  signed coefficient.
REQ-009 SHALL have port coef_ready  output  1  builder accepts a coefficient.
REQ-010 SHALL have port wr_en  output  1  LUT write strobe.
REQ-011 SHALL have port wr_part  output  max(1,$clog2(PARTITION))  target partition index.
REQ-012 SHALL have port wr_addr  output  K  LUT cell address.
REQ-013 SHALL have port wr_data  output  OPSIZE  LUT cell value.
REQ-014 SHALL have port busy  output  1  high in LOAD and BUILD.
REQ-015 SHALL have port done  output  1  one-cycle pulse after last write.

Function
REQ-016 SHALL implement states IDLE, LOAD, BUILD, DONE; all outputs registered.
REQ-017 SHALL leave IDLE for LOAD on the clock edge where start=1; start outside IDLE is ignored.
REQ-018 SHALL drive coef_ready=1 only in LOAD; a transfer occurs on an edge with coef_valid=1 and coef_ready=1.
REQ-019 SHALL store transfers in order as c[0]..c[ORDER-1]; coef_valid=0 stalls LOAD indefinitely without timeout.
REQ-020 SHALL enter BUILD on the edge accepting c[ORDER-1]; coef_ready is 0 in the following cycle.
REQ-021 SHALL, in BUILD, issue exactly one write per cycle, wr_en=1, for p = 0..PARTITION-1 (outer) and a = 0..CELLS-1 (inner), totalling PARTITION*CELLS consecutive cycles.
REQ-022 SHALL compute wr_data for (p, a) as the sum over bits b in 0..K-1 with a[b]=1 of c[p*K+b]; a=0 yields 0.
REQ-023 SHALL perform the summation at OPSIZE+K bits, then reduce to OPSIZE bits per REQ-032/REQ-033.
REQ-024 SHALL enter DONE after the write of (PARTITION-1, CELLS-1), assert done=1 and wr_en=0 for one cycle, then return to IDLE.
REQ-025 SHALL hold wr_en=0 in IDLE, LOAD, and DONE; wr_part, wr_addr, and wr_data are don't-care when wr_en=0.
REQ-026 SHALL retain coefficient registers after DONE until the next LOAD overwrites them.
REQ-027 SHALL take start=1 during the DONE cycle as ignored.

Reset
REQ-028 SHALL on rst=1, regardless of state, enter IDLE and clear all coefficient registers and the p/a counters at the next edge.
REQ-029 SHALL reset outputs to coef_ready=0, wr_en=0, wr_part=0, wr_addr=0, wr_data=0, busy=0, and done=0.
REQ-030 SHALL, on reset during BUILD, emit no further writes; a partially written LUT is not repaired.
REQ-031 SHALL give rst priority over start and coef_valid in the same cycle.

Configuration
REQ-032 SHALL, with macro DA_LUT_SAT_EN defined, saturate the wide sum to [-2^(OPSIZE-1), 2^(OPSIZE-1)-1].
REQ-033 SHALL, without DA_LUT_SAT_EN, truncate the wide sum to its low OPSIZE bits (two's-complement wrap).

Verification
REQ-034 SHALL verify: c = 1,2,4,8,16,32 -> partition 0 addr 7 = 7, partition 1 addr 5 = 40, 16 writes, then done one cycle later.
REQ-035 SHALL verify: c = 0x7FF x6 -> addr 7 = 0x7FF with DA_LUT_SAT_EN and 0x7FD without.
REQ-036 SHALL verify: c0 = c1 = 0x800 -> addr 3 = 0x800 with DA_LUT_SAT_EN and 0x000 without.
REQ-037 SHALL verify: coef_valid toggled 1/0 each cycle -> exactly 6 transfers, BUILD starts after the 6th, and wr_en=0 throughout LOAD.
REQ-038 SHALL verify: rst asserted on the 5th BUILD cycle -> wr_en=0 and busy=0 next cycle, done never pulses, and a later start reloads cleanly.
REQ-039 SHALL verify: start held high continuously -> a new LOAD begins only after DONE-to-IDLE, with no extra writes.

Source files
------------

// File: rtl/da_lut_builder.sv
// Distributed-arithmetic LUT builder: loads ORDER coefficients, then writes every
// partial-sum cell of each partition. Define DA_LUT_SAT_EN to saturate instead of wrap.
module da_lut_builder #(
    parameter int unsigned OPSIZE    = 12,
    parameter int unsigned ORDER     = 6,
    parameter int unsigned PARTITION = 2
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               start,
    input  logic                                               coef_valid,
    input  logic [OPSIZE-1:0]                                  coef_data,
    output logic                                               coef_ready,
    output logic                                               wr_en,
    output logic [((PARTITION > 1) ? $clog2(PARTITION) : 1)-1:0] wr_part,
    output logic [ORDER/PARTITION-1:0]                         wr_addr,
    output logic [OPSIZE-1:0]                                  wr_data,
    output logic                                               busy,
    output logic                                               done
);

    localparam int unsigned K     = ORDER / PARTITION;
    localparam int unsigned CELLS = 1 << K;
    localparam int unsigned PW    = (PARTITION > 1) ? $clog2(PARTITION) : 1;
    localparam int unsigned CW    = (ORDER > 1) ? $clog2(ORDER) : 1;
    localparam int unsigned SW    = OPSIZE + K;

`ifdef DA_LUT_SAT_EN
    localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (OPSIZE - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_BUILD = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [ORDER-1:0][OPSIZE-1:0]  coef_q, coef_d;
    logic [CW-1:0]                 ld_cnt_q, ld_cnt_d;
    logic [PW-1:0]                 p_q, p_d;
    logic [K-1:0]                  a_q, a_d;

    logic                          coef_ready_q, coef_ready_d;
    logic                          wr_en_q, wr_en_d;
    logic [PW-1:0]                 wr_part_q, wr_part_d;
    logic [K-1:0]                  wr_addr_q, wr_addr_d;
    logic [OPSIZE-1:0]             wr_data_q, wr_data_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;

    logic                          xfer;
    logic                          last_write;

    assign xfer       = coef_valid & coef_ready_q;
    assign last_write = (p_q == PW'(PARTITION - 1)) && (a_q == K'(CELLS - 1));

    // Sum of the coefficients of partition p selected by the set bits of a, then narrowed.
    function automatic logic [OPSIZE-1:0] cell_value(
        input logic [ORDER-1:0][OPSIZE-1:0] c,
        input logic [PW-1:0]                p,
        input logic [K-1:0]                 a
    );
        logic signed [SW-1:0] sum;
        sum = '0;
        for (int unsigned pp = 0; pp < PARTITION; pp++) begin
            for (int unsigned b = 0; b < K; b++) begin
                if ((p == PW'(pp)) && a[b]) begin
                    sum = sum + SW'($signed(c[pp*K+b]));
                end
            end
        end
`ifdef DA_LUT_SAT_EN
        if (sum > SAT_MAX) begin
            cell_value = SAT_MAX[OPSIZE-1:0];
        end else if (sum < SAT_MIN) begin
            cell_value = SAT_MIN[OPSIZE-1:0];
        end else begin
            cell_value = sum[OPSIZE-1:0];
        end
`else
        cell_value = sum[OPSIZE-1:0];
`endif
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  if (xfer && (ld_cnt_q == CW'(ORDER - 1))) state_d = S_BUILD;
            S_BUILD: if (last_write) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Coefficient capture and cell counters; counters name the write presented next cycle.
    always_comb begin
        coef_d   = coef_q;
        ld_cnt_d = ld_cnt_q;
        p_d      = '0;
        a_d      = '0;
        if (state_q == S_IDLE) begin
            ld_cnt_d = '0;
        end
        if (xfer) begin
            for (int unsigned i = 0; i < ORDER; i++) begin
                if (ld_cnt_q == CW'(i)) begin
                    coef_d[i] = coef_data;
                end
            end
            ld_cnt_d = ld_cnt_q + CW'(1);
        end
        if ((state_q == S_BUILD) && (state_d == S_BUILD)) begin
            if (a_q == K'(CELLS - 1)) begin
                p_d = p_q + PW'(1);
            end else begin
                p_d = p_q;
                a_d = a_q + K'(1);
            end
        end
    end

    // Output logic, evaluated against the next state so outputs align with the state.
    always_comb begin
        coef_ready_d = (state_d == S_LOAD);
        busy_d       = (state_d == S_LOAD) || (state_d == S_BUILD);
        done_d       = (state_d == S_DONE);
        wr_en_d      = (state_d == S_BUILD);
        wr_part_d    = p_d;
        wr_addr_d    = a_d;
        wr_data_d    = '0;
        if (wr_en_d) begin
            wr_data_d = cell_value(coef_d, p_d, a_d);
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            coef_q       <= '0;
            ld_cnt_q     <= '0;
            p_q          <= '0;
            a_q          <= '0;
            coef_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_part_q    <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            coef_q       <= coef_d;
            ld_cnt_q     <= ld_cnt_d;
            p_q          <= p_d;
            a_q          <= a_d;
            coef_ready_q <= coef_ready_d;
            wr_en_q      <= wr_en_d;
            wr_part_q    <= wr_part_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign coef_ready = coef_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_part    = wr_part_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_da_lut_builder.sv
// Self-checking bench for da_lut_builder against an arithmetic model of the LUT contents.
module tb_da_lut_builder;

    localparam int OPSIZE    = 12;
    localparam int ORDER     = 6;
    localparam int PARTITION = 2;
    localparam int K         = ORDER / PARTITION;
    localparam int CELLS     = 1 << K;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              coef_valid;
    logic [OPSIZE-1:0] coef_data;
    logic              coef_ready;
    logic              wr_en;
    logic [0:0]        wr_part;
    logic [K-1:0]      wr_addr;
    logic [OPSIZE-1:0] wr_data;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_pass   = 0;
    int cq[ORDER];

    da_lut_builder #(.OPSIZE(OPSIZE), .ORDER(ORDER), .PARTITION(PARTITION)) dut (
        .clk(clk), .rst(rst), .start(start), .coef_valid(coef_valid),
        .coef_data(coef_data), .coef_ready(coef_ready), .wr_en(wr_en),
        .wr_part(wr_part), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected cell: plain integer sum of selected coefficients, then wrap or clamp.
    function automatic int exp_cell(input int p, input int a);
        int s = 0;
        for (int b = 0; b < K; b++)
            if (((a >> b) & 1) == 1) s += cq[p*K+b];
`ifdef DA_LUT_SAT_EN
        if (s > 2047) s = 2047;
        if (s < -2048) s = -2048;
`endif
        return s & ((1 << OPSIZE) - 1);
    endfunction

    function automatic int to_signed12(input int v);
        return (v >= 2048) ? v - 4096 : v;
    endfunction

    task automatic rand_coefs();
        for (int i = 0; i < ORDER; i++) cq[i] = to_signed12(int'($urandom_range(0, 4095)));
    endtask

    // vmode: 0 valid always, 1 valid toggling, 2 random valid.
    task automatic do_build(input int vmode, input bit hold_start);
        int  n = 0;
        int  guard = 0;
        bit  xfer;
        start = 1'b1;
        step();
        if (!hold_start) start = 1'b0;
        check("load_busy", 32'(busy), 32'd1);
        while (n < ORDER && guard < 400) begin
            case (vmode)
                0:       coef_valid = 1'b1;
                1:       coef_valid = (guard % 2) == 0;
                default: coef_valid = 1'($urandom_range(0, 1));
            endcase
            coef_data = 12'(cq[n]);
            check("load_wr_en", 32'(wr_en), 32'd0);
            check("load_coef_ready", 32'(coef_ready), 32'd1);
            xfer = coef_valid && coef_ready;
            step();
            guard++;
            if (xfer) n++;
        end
        coef_valid = 1'b0;
        if (n < ORDER) begin
            check("load_timeout", 32'(n), 32'(ORDER));
            return;
        end
        check("build_ready_low", 32'(coef_ready), 32'd0);
        for (int p = 0; p < PARTITION; p++) begin
            for (int a = 0; a < CELLS; a++) begin
                check("wr_en", 32'(wr_en), 32'd1);
                check("wr_part", 32'(wr_part), 32'(p));
                check("wr_addr", 32'(wr_addr), 32'(a));
                check($sformatf("wr_data_p%0d_a%0d", p, a), 32'(wr_data), 32'(exp_cell(p, a)));
                check("build_done_low", 32'(done), 32'd0);
                step();
            end
        end
        check("done_pulse", 32'(done), 32'd1);
        check("done_wr_en", 32'(wr_en), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        step();
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ready", 32'(coef_ready), 32'd0);
        check("idle_wr_en", 32'(wr_en), 32'd0);
    endtask

    task automatic reset_mid_build();
        rand_coefs();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < ORDER; i++) begin
            coef_valid = 1'b1;
            coef_data  = 12'(cq[i]);
            step();
        end
        coef_valid = 1'b0;
        repeat (4) step();
        check("rst5_wr_en", 32'(wr_en), 32'd1);
        check("rst5_wr_addr", 32'(wr_addr), 32'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(coef_ready), 32'd0);
        for (int i = 0; i < 20; i++) begin
            check("post_rst_done", 32'(done), 32'd0);
            check("post_rst_wr_en", 32'(wr_en), 32'd0);
            step();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; coef_valid = 1'b0; coef_data = '0;
        repeat (3) step();
        check("rst_coef_ready", 32'(coef_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_part", 32'(wr_part), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        step();

        cq = '{1, 2, 4, 8, 16, 32};
        do_build(0, 1'b0);
        cq = '{2047, 2047, 2047, 2047, 2047, 2047};
        do_build(0, 1'b0);
        cq = '{-2048, -2048, 0, 0, 0, 0};
        do_build(0, 1'b0);
        rand_coefs();
        do_build(1, 1'b0);

        reset_mid_build();
        rand_coefs();
        do_build(2, 1'b0);

        rand_coefs();
        do_build(2, 1'b1);
        rand_coefs();
        do_build(0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            rand_coefs();
            do_build(2, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
